// File: rtl/fp_mult_norm_round_pkg.sv
// Shared constants for the FP multiply normalize/round stage: product and
// significand widths, key bit positions in the product, and FSM encodings.
package fp_mult_norm_round_pkg;

   localparam int PROD_W     = 56;
   localparam int MAN_OUT_W  = 24;
   localparam int HIDDEN_POS = 54;
   localparam int GUARD_POS  = 30;

   typedef logic [PROD_W-1:0]    prod_t;
   typedef logic [MAN_OUT_W-1:0] man_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_NORM  = 2'd1;
   localparam logic [1:0] ST_ROUND = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/fp_mult_norm_round_rne_round.sv
// Round-to-nearest-even on a 24-bit significand given guard and sticky bits.
// A carry out of the increment yields 1.000... and is reported so the caller
// can bump the exponent.
module rne_round
   import fp_mult_norm_round_pkg::*;
(
   input  logic [MAN_OUT_W-1:0] man_i,
   input  logic                 guard_i,
   input  logic                 sticky_i,
   output logic [MAN_OUT_W-1:0] man_o,
   output logic                 carry_o
);

   logic           roundUp;
   logic [MAN_OUT_W:0] sum;

   // Increment on above-half, or exactly half with an odd LSB; renormalize a carry-out
   always_comb begin
      roundUp = guard_i & (sticky_i | man_i[0]);
      sum     = {1'b0, man_i} + {{MAN_OUT_W{1'b0}}, roundUp};
      carry_o = sum[MAN_OUT_W];
      man_o   = carry_o ? {1'b1, {(MAN_OUT_W-1){1'b0}}} : sum[MAN_OUT_W-1:0];
   end

endmodule

// File: rtl/fp_mult_norm_round.sv
// Normalize/round stage after the mantissa multiplier. Captures the 56-bit
// product on a rising done level, normalizes it (one shift per cycle),
// rounds to nearest even and hands the result to the packer via valid/ready.
module fp_mult_norm_round
   import fp_mult_norm_round_pkg::*;
#(
   parameter int EXP_W   = 10,
   parameter int EXP_MIN = 1,
   parameter int EXP_MAX = 254
) (
   input  logic                 clk,
   input  logic                 reset_n_i,
   input  logic                 mult_done_i,
   input  logic [27:0]          product_high_i,
   input  logic [27:0]          product_low_i,
   input  logic [EXP_W-1:0]     exp_i,
   input  logic                 sign_i,
   input  logic                 ready_i,
   output logic                 valid_o,
   output logic                 sign_o,
   output logic [EXP_W-1:0]     exp_o,
   output logic [MAN_OUT_W-1:0] man_o,
   output logic                 inexact_o,
   output logic                 overflow_o,
   output logic                 underflow_o,
   output logic                 busy_o,
   output logic                 lost_o
);

   localparam logic signed [EXP_W-1:0] EXP_MIN_W = EXP_W'(EXP_MIN);
   localparam logic signed [EXP_W-1:0] EXP_MAX_W = EXP_W'(EXP_MAX);
   localparam logic signed [EXP_W-1:0] EXP_OVF_W = EXP_W'(EXP_MAX + 1);
   localparam logic signed [EXP_W-1:0] ONE_W     = EXP_W'(1);

   logic [1:0]              state_q, state_d;
   logic                    doneDly_q;
   prod_t                   prod_q, prod_d;
   logic signed [EXP_W-1:0] exp_q, exp_d;
   logic                    sign_q, sign_d;
   logic                    sticky_q, sticky_d;
   logic                    zero_q, zero_d;

   logic                    valid_q, valid_d;
   logic                    signOut_q, signOut_d;
   logic [EXP_W-1:0]        expOut_q, expOut_d;
   man_t                    manOut_q, manOut_d;
   logic                    inexact_q, inexact_d;
   logic                    overflow_q, overflow_d;
   logic                    underflow_q, underflow_d;
   logic                    lost_q, lost_d;

   logic                    doneRise;
   man_t                    manRaw, manRnd;
   logic                    guardBit, stickyAll, rndCarry;
   logic signed [EXP_W-1:0] expRnd;

   assign doneRise  = mult_done_i & ~doneDly_q;
   assign manRaw    = prod_q[HIDDEN_POS -: MAN_OUT_W];
   assign guardBit  = prod_q[GUARD_POS];
   assign stickyAll = (|prod_q[GUARD_POS-1:0]) | sticky_q;
   assign expRnd    = rndCarry ? (exp_q + ONE_W) : exp_q;

   rne_round u_rne_round (
      .man_i    (manRaw),
      .guard_i  (guardBit),
      .sticky_i (stickyAll),
      .man_o    (manRnd),
      .carry_o  (rndCarry)
   );

   // Next-state logic: capture, one normalization step per cycle, round, hold for handshake
   always_comb begin
      state_d     = state_q;
      prod_d      = prod_q;
      exp_d       = exp_q;
      sign_d      = sign_q;
      sticky_d    = sticky_q;
      zero_d      = zero_q;
      valid_d     = valid_q;
      signOut_d   = signOut_q;
      expOut_d    = expOut_q;
      manOut_d    = manOut_q;
      inexact_d   = inexact_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      lost_d      = doneRise & (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (doneRise) begin
               prod_d   = {product_high_i, product_low_i};
               exp_d    = exp_i;
               sign_d   = sign_i;
               sticky_d = 1'b0;
               zero_d   = 1'b0;
               state_d  = ST_NORM;
            end
         end
         ST_NORM: begin
            if (prod_q == '0) begin
               zero_d  = 1'b1;
               state_d = ST_ROUND;
            end else if (prod_q[PROD_W-1]) begin
               prod_d   = prod_q >> 1;
               sticky_d = sticky_q | prod_q[0];
               exp_d    = exp_q + ONE_W;
               state_d  = ST_ROUND;
            end else if (prod_q[HIDDEN_POS]) begin
               state_d = ST_ROUND;
            end else if (exp_q > EXP_MIN_W) begin
               prod_d = prod_q << 1;
               exp_d  = exp_q - ONE_W;
            end else begin
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            valid_d     = 1'b1;
            signOut_d   = sign_q;
            expOut_d    = '0;
            manOut_d    = '0;
            inexact_d   = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            if (zero_q) begin
               expOut_d = '0;
            end else if ((expRnd < EXP_MIN_W) || !prod_q[HIDDEN_POS]) begin
               underflow_d = 1'b1;
               inexact_d   = 1'b1;
            end else if (expRnd > EXP_MAX_W) begin
               overflow_d = 1'b1;
               expOut_d   = EXP_OVF_W;
               inexact_d  = 1'b1;
            end else begin
               expOut_d  = expRnd;
               manOut_d  = manRnd;
               inexact_d = guardBit | stickyAll;
            end
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (ready_i) begin
               valid_d     = 1'b0;
               signOut_d   = 1'b0;
               expOut_d    = '0;
               manOut_d    = '0;
               inexact_d   = 1'b0;
               overflow_d  = 1'b0;
               underflow_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; done-delay tracks the input every cycle
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_IDLE;
         doneDly_q   <= 1'b0;
         prod_q      <= '0;
         exp_q       <= '0;
         sign_q      <= 1'b0;
         sticky_q    <= 1'b0;
         zero_q      <= 1'b0;
         valid_q     <= 1'b0;
         signOut_q   <= 1'b0;
         expOut_q    <= '0;
         manOut_q    <= '0;
         inexact_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         doneDly_q   <= mult_done_i;
         prod_q      <= prod_d;
         exp_q       <= exp_d;
         sign_q      <= sign_d;
         sticky_q    <= sticky_d;
         zero_q      <= zero_d;
         valid_q     <= valid_d;
         signOut_q   <= signOut_d;
         expOut_q    <= expOut_d;
         manOut_q    <= manOut_d;
         inexact_q   <= inexact_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         lost_q      <= lost_d;
      end
   end

   assign valid_o     = valid_q;
   assign sign_o      = signOut_q;
   assign exp_o       = expOut_q;
   assign man_o       = manOut_q;
   assign inexact_o   = inexact_q;
   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign lost_o      = lost_q;

endmodule

// File: tb/tb_fp_mult_norm_round.sv
// Directed bench for fp_mult_norm_round with an expected-result queue.
module tb_fp_mult_norm_round;

   typedef struct {
      logic        sign;
      logic [9:0]  expo;
      logic [23:0] man;
      logic        inx;
      logic        ovf;
      logic        udf;
      int          lat;
   } expect_t;

   logic        clk;
   logic        reset_n_i;
   logic        mult_done_i;
   logic [27:0] product_high_i;
   logic [27:0] product_low_i;
   logic [9:0]  exp_i;
   logic        sign_i;
   logic        ready_i;
   logic        valid_o;
   logic        sign_o;
   logic [9:0]  exp_o;
   logic [23:0] man_o;
   logic        inexact_o;
   logic        overflow_o;
   logic        underflow_o;
   logic        busy_o;
   logic        lost_o;

   int total = 0;
   int bad   = 0;
   expect_t sb[$];
   expect_t cur;
   int      extraValid;

   fp_mult_norm_round dut (
      .clk            (clk),
      .reset_n_i      (reset_n_i),
      .mult_done_i    (mult_done_i),
      .product_high_i (product_high_i),
      .product_low_i  (product_low_i),
      .exp_i          (exp_i),
      .sign_i         (sign_i),
      .ready_i        (ready_i),
      .valid_o        (valid_o),
      .sign_o         (sign_o),
      .exp_o          (exp_o),
      .man_o          (man_o),
      .inexact_o      (inexact_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o),
      .busy_o         (busy_o),
      .lost_o         (lost_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput(input string tag, input expect_t e);
      checkVal({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
      checkVal({tag, ".sign"}, {31'd0, sign_o}, {31'd0, e.sign});
      checkVal({tag, ".exp"}, {22'd0, exp_o}, {22'd0, e.expo});
      checkVal({tag, ".man"}, {8'd0, man_o}, {8'd0, e.man});
      checkVal({tag, ".flags"}, {29'd0, inexact_o, overflow_o, underflow_o},
               {29'd0, e.inx, e.ovf, e.udf});
   endtask

   // Drive a product with done raised; the expected result is queued now
   task automatic applyStimulus(input logic [27:0] hi, input logic [27:0] lo,
                                input logic [9:0] e, input logic s, input expect_t ex);
      sb.push_back(ex);
      product_high_i = hi;
      product_low_i  = lo;
      exp_i          = e;
      sign_i         = s;
      mult_done_i    = 1'b1;
   endtask

   // Wait (bounded) for valid_o, check latency, then compare against the queue head
   task automatic waitResult(input string tag);
      int cyc;
      expect_t e;
      cyc = 0;
      while (!valid_o && cyc < 200) begin
         stepClk();
         cyc++;
      end
      checkVal({tag, ".seen"}, {31'd0, valid_o}, 32'd1);
      if (sb.size() == 0) begin
         checkVal({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         checkVal({tag, ".lat"}, cyc, e.lat);
         checkOutput(tag, e);
      end
   endtask

   // Complete a handshake with ready high and confirm valid drops
   task automatic finishCase(input string tag);
      mult_done_i = 1'b0;
      ready_i     = 1'b1;
      stepClk();
      checkVal({tag, ".drop"}, {31'd0, valid_o}, 32'd0);
   endtask

   function automatic expect_t mk(input logic s, input logic [9:0] ex, input logic [23:0] m,
                                  input logic inx, input logic ovf, input logic udf, input int lat);
      expect_t r;
      r.sign = s; r.expo = ex; r.man = m; r.inx = inx; r.ovf = ovf; r.udf = udf; r.lat = lat;
      return r;
   endfunction

   initial begin
      reset_n_i      = 1'b0;
      mult_done_i    = 1'b0;
      product_high_i = '0;
      product_low_i  = '0;
      exp_i          = '0;
      sign_i         = 1'b0;
      ready_i        = 1'b1;
      stepClk();
      stepClk();
      checkVal("reset.outs", {valid_o, sign_o, exp_o, man_o, inexact_o, overflow_o,
                              underflow_o, busy_o, lost_o},
               32'd0);
      reset_n_i = 1'b1;
      stepClk();
      checkVal("reset.busy", {31'd0, busy_o}, 32'd0);

      applyStimulus(28'h4000000, 28'h0, 10'd127, 1'b1, mk(1'b1, 10'd127, 24'h800000, 0, 0, 0, 3));
      waitResult("normal");
      finishCase("normal");

      applyStimulus(28'hC000000, 28'h0, 10'd127, 1'b0, mk(1'b0, 10'd128, 24'hC00000, 0, 0, 0, 3));
      waitResult("p55");
      finishCase("p55");

      applyStimulus(28'h4000004, 28'h0, 10'd127, 1'b0, mk(1'b0, 10'd127, 24'h800000, 1, 0, 0, 3));
      waitResult("tieEven");
      finishCase("tieEven");

      applyStimulus(28'h400000C, 28'h0, 10'd127, 1'b0, mk(1'b0, 10'd127, 24'h800002, 1, 0, 0, 3));
      waitResult("tieOdd");
      finishCase("tieOdd");

      applyStimulus(28'h4000004, 28'h1, 10'd127, 1'b0, mk(1'b0, 10'd127, 24'h800001, 1, 0, 0, 3));
      waitResult("aboveHalf");
      finishCase("aboveHalf");

      applyStimulus(28'h7FFFFFC, 28'h0, 10'd127, 1'b0, mk(1'b0, 10'd128, 24'h800000, 1, 0, 0, 3));
      waitResult("rndCarry");
      finishCase("rndCarry");

      applyStimulus(28'h1000000, 28'h0, 10'd127, 1'b0, mk(1'b0, 10'd125, 24'h800000, 0, 0, 0, 5));
      waitResult("leftNorm");
      finishCase("leftNorm");

      applyStimulus(28'h0, 28'h0, 10'd127, 1'b0, mk(1'b0, 10'd0, 24'h0, 0, 0, 0, 3));
      waitResult("zero");
      finishCase("zero");

      applyStimulus(28'h4000000, 28'h0, 10'd0, 1'b0, mk(1'b0, 10'd0, 24'h0, 1, 0, 1, 3));
      waitResult("underflow");
      finishCase("underflow");

      applyStimulus(28'hC000000, 28'h0, 10'd254, 1'b0, mk(1'b0, 10'd255, 24'h0, 1, 1, 0, 3));
      waitResult("overflow");
      finishCase("overflow");

      // Stall with ready low, retrigger done during HOLD to provoke a lost pulse
      ready_i = 1'b0;
      cur = mk(1'b0, 10'd127, 24'h800002, 1, 0, 0, 3);
      applyStimulus(28'h400000C, 28'h0, 10'd127, 1'b0, cur);
      waitResult("stall");
      for (int i = 0; i < 10; i++) begin
         stepClk();
         checkOutput("stallHold", cur);
      end
      mult_done_i = 1'b0;
      stepClk();
      checkVal("lost.idle", {31'd0, lost_o}, 32'd0);
      mult_done_i = 1'b1;
      stepClk();
      checkVal("lost.pulse", {31'd0, lost_o}, 32'd1);
      stepClk();
      checkVal("lost.clear", {31'd0, lost_o}, 32'd0);
      checkOutput("stallAfterLost", cur);
      ready_i = 1'b1;
      stepClk();
      checkVal("stall.drop", {31'd0, valid_o}, 32'd0);
      extraValid = 0;
      for (int i = 0; i < 10; i++) begin
         stepClk();
         if (valid_o) extraValid++;
      end
      checkVal("lost.noExtra", extraValid, 32'd0);
      mult_done_i = 1'b0;
      stepClk();

      // Reset in the middle of a long left normalization
      applyStimulus(28'h0000001, 28'h0, 10'd127, 1'b0, mk(1'b0, 10'd0, 24'h0, 0, 0, 0, 0));
      stepClk();
      stepClk();
      stepClk();
      checkVal("midNorm.busy", {31'd0, busy_o}, 32'd1);
      #2;
      reset_n_i = 1'b0;
      #1;
      checkVal("midNorm.reset", {valid_o, sign_o, exp_o, man_o, inexact_o, overflow_o,
                                 underflow_o, busy_o, lost_o},
               32'd0);
      void'(sb.pop_back());
      mult_done_i = 1'b0;
      stepClk();
      reset_n_i = 1'b1;
      extraValid = 0;
      for (int i = 0; i < 80; i++) begin
         stepClk();
         if (valid_o || busy_o) extraValid++;
      end
      checkVal("midNorm.noResult", extraValid, 32'd0);
      checkVal("sb.empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
